// File: rtl/tdp_ram_sync_clr.sv
// True dual-port RAM with a post-reset clear sweep.
// After rst_n releases, every word is written to zero (one word per cycle)
// while busy is high; both ports are then usable from the first READY cycle.
// Port A wins a same-address dual write and coll pulses for one cycle.
// Optional macro TDP_RAM_OUTREG_EN adds a second output register stage on
// doutA/doutB/coll (read latency 2). Without it read latency is 1.
module tdp_ram_sync_clr #(
  parameter int DATA_W   = 10,
  parameter int ADDR_W   = 9,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  input  logic              weA,
  input  logic              weB,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] dinA,
  input  logic [DATA_W-1:0] dinB,
  output logic [DATA_W-1:0] doutA,
  output logic [DATA_W-1:0] doutB,
  output logic              coll
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W:0]     clr_cnt_q;
  logic [ADDR_W:0]     clr_cnt_d;
  logic                busy_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [DATA_W-1:0]   rdA_q, rdB_q;
  logic [DATA_W-1:0]   rdA_d, rdB_d;
  logic                coll_q, coll_d;

  logic                same_addr;
  logic                dual_wr;
  logic                wrB_ok;

  // Counter is one bit wider than the address so it never wraps back into
  // the array after the final word is cleared.
  assign clr_cnt_d = clr_cnt_q + (ADDR_W + 1)'(1);

  assign same_addr = (addrA == addrB);
  assign dual_wr   = weA && weB && same_addr;
  // Port B's write is dropped when it collides with port A.
  assign wrB_ok    = weB && !dual_wr;

  // Clear-sweep FSM: CLEAR walks every address once, then parks in READY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_d;
          if (clr_cnt_q == LAST_ADDR) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= CLEAR;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Array write: the sweep owns the array while clearing; reset never
  // touches it directly. Port A is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        mem[clr_cnt_q[ADDR_W-1:0]] <= '0;
      end else begin
        if (wrB_ok) mem[addrB] <= dinB;
        if (weA)    mem[addrA] <= dinA;
      end
    end
  end

  // Next read data: own-port write data in write-first mode, otherwise the
  // stored (pre-write) word, which also covers cross-port reads.
  always_comb begin
    rdA_d  = mem[addrA];
    rdB_d  = mem[addrB];
    coll_d = dual_wr;
    if (RDW_MODE == 1) begin
      if (weA) rdA_d = dinA;
      if (weB) rdB_d = dinB;
    end
  end

  // First output stage: held at zero during reset and the clear sweep.
  always_ff @(posedge clk) begin
    if (!rst_n || busy_q) begin
      rdA_q  <= '0;
      rdB_q  <= '0;
      coll_q <= 1'b0;
    end else begin
      rdA_q  <= rdA_d;
      rdB_q  <= rdB_d;
      coll_q <= coll_d;
    end
  end

`ifdef TDP_RAM_OUTREG_EN
  logic [DATA_W-1:0] outA_q, outB_q;
  logic              outC_q;

  // Second output stage for timing; adds one cycle to data and coll.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outA_q <= '0;
      outB_q <= '0;
      outC_q <= 1'b0;
    end else begin
      outA_q <= rdA_q;
      outB_q <= rdB_q;
      outC_q <= coll_q;
    end
  end

  assign doutA = outA_q;
  assign doutB = outB_q;
  assign coll  = outC_q;
`else
  assign doutA = rdA_q;
  assign doutB = rdB_q;
  assign coll  = coll_q;
`endif

  assign busy = busy_q;

endmodule

// File: tb/tb_tdp_ram_sync_clr.sv
// Self-checking bench for tdp_ram_sync_clr: directed scenarios plus a
// randomized run scored against an array model of the memory.
module tb_tdp_ram_sync_clr;

  localparam int DW    = 10;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int RDW   = 0;
`ifdef TDP_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          busy;
  logic          weA, weB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] dinA, dinB;
  logic [DW-1:0] doutA, doutB;
  logic          coll;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: memory contents plus per-cycle expected outputs.
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] qA[$];
  logic [DW-1:0] qB[$];
  logic          qC[$];

  always #5 clk = ~clk;

  tdp_ram_sync_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(RDW)) dut (
    .clk(clk), .rst_n(rst_n), .busy(busy),
    .weA(weA), .weB(weB), .addrA(addrA), .addrB(addrB),
    .dinA(dinA), .dinB(dinB), .doutA(doutA), .doutB(doutB), .coll(coll)
  );

  // One READY cycle: drive ports, predict outputs, update model.
  task automatic step(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    @(negedge clk);
    weA = wa; addrA = aa; dinA = da;
    weB = wb; addrB = ab; dinB = db;
    qA.push_back((RDW == 1 && wa) ? da : mdl[aa]);
    qB.push_back((RDW == 1 && wb) ? db : mdl[ab]);
    qC.push_back(wa && wb && (aa == ab));
    if (wb) mdl[ab] = db;
    if (wa) mdl[aa] = da;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Release reset and follow the sweep; optionally re-pulse reset after
  // abort_at sweep cycles. Random writes are driven throughout.
  task automatic run_sweep(input int abort_at, output int cnt, output int bad);
    bit aborted = 0;
    bit in_rst;
    cnt = 0;
    bad = 0;
    while (cnt < 3000) begin
      @(negedge clk);
      weA = 1'($urandom_range(0, 1)); addrA = AW'($urandom); dinA = DW'($urandom);
      weB = 1'($urandom_range(0, 1)); addrB = AW'($urandom); dinB = DW'($urandom);
      in_rst = (!aborted && cnt == abort_at);
      rst_n  = !in_rst;
      @(posedge clk); #1;
      if (in_rst) begin
        aborted = 1;
        cnt = 0;
        if (busy !== 1'b1 || doutA !== '0 || doutB !== '0 || coll !== 1'b0) bad++;
      end else begin
        cnt++;
        if (busy === 1'b1 && (doutA !== '0 || doutB !== '0 || coll !== 1'b0)) bad++;
        if (busy !== 1'b1) break;
      end
    end
    weA = 1'b0; weB = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    qA.delete(); qB.delete(); qC.delete();
  endtask

  task automatic test_reset();
    int cnt, bad;
    rst_n = 1'b0; weA = 0; weB = 0; addrA = 0; addrB = 0; dinA = 0; dinB = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", busy); end
    n_chk++; if (doutA !== '0) begin n_fail++; $display("FAIL rst_doutA: got %h want 0", doutA); end
    n_chk++; if (doutB !== '0) begin n_fail++; $display("FAIL rst_doutB: got %h want 0", doutB); end
    n_chk++; if (coll !== 1'b0) begin n_fail++; $display("FAIL rst_coll: got %b want 0", coll); end
    run_sweep(-1, cnt, bad);
    n_chk++; if (cnt != 512) begin n_fail++; $display("FAIL sweep_len: got %0d want 512", cnt); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL sweep_quiet: got %0d bad cycles want 0", bad); end
    step(1'b0, AW'(0), '0, 1'b0, AW'(511), '0);
    repeat (LAT - 1) idle();
    n_chk++; if (doutA !== '0) begin n_fail++; $display("FAIL clr_rd0: got %h want 0", doutA); end
    n_chk++; if (doutB !== '0) begin n_fail++; $display("FAIL clr_rd511: got %h want 0", doutB); end
    step(1'b0, AW'(255), '0, 1'b0, AW'(255), '0);
    repeat (LAT - 1) idle();
    n_chk++; if (doutA !== '0) begin n_fail++; $display("FAIL clr_rd255: got %h want 0", doutA); end
  endtask

  task automatic test_write_read();
    step(1'b1, AW'(7), DW'('h155), 1'b0, AW'(0), '0);
    step(1'b0, AW'(0), '0, 1'b0, AW'(7), '0);
    repeat (LAT - 1) idle();
    n_chk++; if (doutB !== DW'('h155)) begin n_fail++; $display("FAIL wr_rd_B: got %h want 155", doutB); end
  endtask

  task automatic test_collision();
    step(1'b1, AW'(20), DW'('h3FF), 1'b1, AW'(20), DW'('h001));
    repeat (LAT - 1) idle();
    n_chk++; if (coll !== 1'b1) begin n_fail++; $display("FAIL coll_pulse: got %b want 1", coll); end
    idle();
    n_chk++; if (coll !== 1'b0) begin n_fail++; $display("FAIL coll_once: got %b want 0", coll); end
    step(1'b0, AW'(20), '0, 1'b0, AW'(20), '0);
    repeat (LAT - 1) idle();
    n_chk++; if (doutA !== DW'('h3FF)) begin n_fail++; $display("FAIL coll_winA: got %h want 3ff", doutA); end
    n_chk++; if (doutB !== DW'('h3FF)) begin n_fail++; $display("FAIL coll_winB: got %h want 3ff", doutB); end
  endtask

  task automatic test_rdw();
    logic [DW-1:0] expA;
    expA = (RDW == 1) ? DW'('h111) : DW'('h0AA);
    step(1'b1, AW'(5), DW'('h0AA), 1'b0, AW'(0), '0);
    step(1'b1, AW'(5), DW'('h111), 1'b0, AW'(5), '0);
    repeat (LAT - 1) idle();
    n_chk++; if (doutA !== expA) begin n_fail++; $display("FAIL rdw_sameport: got %h want %h", doutA, expA); end
    n_chk++; if (doutB !== DW'('h0AA)) begin n_fail++; $display("FAIL rdw_crossport: got %h want 0aa", doutB); end
  endtask

  task automatic test_random();
    logic [DW-1:0] eA, eB;
    logic          eC;
    qA.delete(); qB.delete(); qC.delete();
    for (int i = 0; i < 400 + LAT - 1; i++) begin
      if (i < 400) begin
        step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
             1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
      end else begin
        idle();
      end
      if (qA.size() == LAT) begin
        eA = qA.pop_front(); eB = qB.pop_front(); eC = qC.pop_front();
        n_chk++; if (doutA !== eA) begin n_fail++; $display("FAIL rand_doutA[%0d]: got %h want %h", i, doutA, eA); end
        n_chk++; if (doutB !== eB) begin n_fail++; $display("FAIL rand_doutB[%0d]: got %h want %h", i, doutB, eB); end
        n_chk++; if (coll !== eC) begin n_fail++; $display("FAIL rand_coll[%0d]: got %b want %b", i, coll, eC); end
      end
    end
  endtask

  task automatic test_mid_sweep_reset();
    int cnt, bad;
    logic [DW-1:0] eA, eB;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_sweep(100, cnt, bad);
    n_chk++; if (cnt != 512) begin n_fail++; $display("FAIL resweep_len: got %0d want 512", cnt); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL resweep_quiet: got %0d bad cycles want 0", bad); end
    for (int i = 0; i < 256 + LAT - 1; i++) begin
      if (i < 256) step(1'b0, AW'(i), '0, 1'b0, AW'(i + 256), '0);
      else idle();
      if (qA.size() == LAT) begin
        eA = qA.pop_front(); eB = qB.pop_front(); void'(qC.pop_front());
        n_chk++; if (doutA !== eA) begin n_fail++; $display("FAIL zero_A[%0d]: got %h want %h", i, doutA, eA); end
        n_chk++; if (doutB !== eB) begin n_fail++; $display("FAIL zero_B[%0d]: got %h want %h", i, doutB, eB); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_rdw();
    test_random();
    test_mid_sweep_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tdp_ram_sync_clr.md
TDP_RAM_SYNC_CLR -- requirements
Module: tdp_ram_sync_clr

Interface
REQ-001 SHALL have parameter DATA_W, default 10: data width per word, in bits.
REQ-002 SHALL have parameter ADDR_W, default 9: address width; DEPTH = 2**ADDR_W words (512 by default).
REQ-003 SHALL have parameter RDW_MODE, default 0: same-port read-during-write; 0 = read-first (old data), 1 = write-first (new data).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port busy, output, 1: high while the post-reset clear sweep runs.
REQ-007 SHALL have ports weA and weB, input, 1 each: write enables for port A and port B.
REQ-008 SHALL have ports addrA and addrB, input, ADDR_W each: addresses for port A and port B.
REQ-009 SHALL have ports dinA and dinB, input, DATA_W each: write data for port A and port B.
REQ-010 SHALL have ports doutA and doutB, output, DATA_W each: registered read data for port A and port B.
REQ-011 SHALL have port coll, output, 1: one-cycle pulse on a same-address dual write.

Function
REQ-012 SHALL read on every non-busy cycle; doutX equals mem[addrX] one clk after sampling (latency 1).
REQ-013 SHALL write dinX to mem[addrX] at the clk edge when weX=1 and busy=0.
REQ-014 SHALL, on a same-port read during write, drive doutX with the old word if RDW_MODE=0, or with dinX if RDW_MODE=1.
REQ-015 SHALL, when one port writes an address that the other port reads in the same cycle, give the reading port the old word.
REQ-016 SHALL, when weA=weB=1 and addrA==addrB, let port A win (mem gets dinA) and assert coll for exactly that following cycle.
REQ-017 SHALL have a clear FSM with states CLEAR and READY.
REQ-018 SHALL, in CLEAR, write 0 to mem[clr_cnt] each cycle and increment clr_cnt, starting at 0.
REQ-019 SHALL move from CLEAR to READY on the cycle that clears address DEPTH-1, so the sweep takes exactly DEPTH cycles after rst_n rises.
REQ-020 SHALL hold busy=1 in CLEAR and busy=0 in READY.
REQ-021 SHALL, while busy=1, ignore weA and weB, hold doutA and doutB at 0, and hold coll at 0.
REQ-022 SHALL compute clr_cnt as ADDR_W+1 bits with no wrap; terminal detection is at DEPTH-1.
REQ-023 SHALL accept port accesses from the first cycle in READY.

Reset
REQ-024 SHALL, on any edge with rst_n=0, set the state to CLEAR, clr_cnt=0, busy=1, doutA=0, doutB=0 and coll=0.
REQ-025 SHALL, if reset is asserted mid-sweep or in READY, abandon the current operation and restart the sweep from address 0 after release.
REQ-026 SHALL not write the memory array while rst_n=0; clearing occurs only via the sweep.

Configuration
REQ-027 SHALL use macro TDP_RAM_OUTREG_EN to select the output pipeline depth.
REQ-028 SHALL, with TDP_RAM_OUTREG_EN defined, add a second output register stage on doutA, doutB and coll, making read latency 2 and delaying the coll pulse by 1 cycle; these registers reset to 0.
REQ-029 SHALL, without TDP_RAM_OUTREG_EN, have read latency 1 with no extra registers.

Verification
REQ-030 SHALL cover: rst_n low for 3 cycles then high -> busy=1 for exactly 512 cycles, then 0; reading addresses 0, 255 and 511 returns 0.
REQ-031 SHALL cover: A writes 0x155 to address 7, then B reads address 7 -> doutB=0x155 one cycle later (two cycles with TDP_RAM_OUTREG_EN).
REQ-032 SHALL cover: A writes 0x3FF and B writes 0x001 to address 20 in the same cycle -> coll pulses once; a later read of address 20 returns 0x3FF.
REQ-033 SHALL cover: mem[5]=0x0AA, then A writes 0x111 to address 5 -> doutA=0x0AA with RDW_MODE=0 and 0x111 with RDW_MODE=1; B reading address 5 in the same cycle gets 0x0AA.
REQ-034 SHALL cover: rst_n pulsed low at sweep cycle 100 -> busy stays 1 for another 512 cycles after release; weA asserted during the sweep leaves the memory all zero.
